// File: rtl/core_read_sequencer.sv
// Core memory read sequencer: two-port round-robin arbitration, one core cycle per syllable, drive-detect check.
// Latency: ack 17 cycles after the IDLE sample (33 for a word); requesters stall by holding req until their ack.
module core_read_sequencer #(
  parameter int SETUP_CYC   = 2,
  parameter int SYNC_CYC    = 2,
  parameter int SAMPLE_CYC  = 10,
  parameter int RECOVER_CYC = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        a_req,
  input  logic [11:0] a_addr,
  input  logic        a_syl,
  output logic        a_ack,
  output logic [13:0] a_data,
  input  logic        b_req,
  input  logic [11:0] b_addr,
  input  logic        b_word,
  input  logic        b_syl,
  output logic        b_ack,
  output logic [27:0] b_data,
  output logic        rsp_err,
  output logic [7:0]  ax_n,
  output logic [7:0]  ay_n,
  output logic [7:0]  ax0_n,
  output logic [7:0]  ay0_n,
  output logic        syl0_n,
  output logic        syl1_n,
  output logic        rdm_v,
  output logic        rdm_vn,
  output logic        sync_v,
  output logic        inhbs_v,
  input  logic [13:0] sa,
  input  logic        ed_x,
  input  logic        ed_y
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    SYNC    = 3'd2,
    SAMPLE  = 3'd3,
    RECOVER = 3'd4,
    DONE    = 3'd5
  } state_t;

  typedef struct packed {
    logic        portB;
    logic        word;
    logic [11:0] addr;
  } txn_t;

  localparam logic [5:0] SETUP_LAST   = 6'(SETUP_CYC - 1);
  localparam logic [5:0] SAMPLE_LAST  = 6'(SAMPLE_CYC - 1);
  localparam logic [5:0] RECOVER_LAST = 6'(RECOVER_CYC - 1);
  localparam logic [5:0] SYNC_WIDTH   = 6'(SYNC_CYC);

  state_t      state;
  state_t      nextState;
  logic [5:0]  timer;
  txn_t        txn;
  logic        sylCur;
  logic        lastGrantB;
  logic        edxSeen;
  logic        edySeen;
  logic        errAcc;
  logic [27:0] wordQ;

  logic        grantB;
  logic        lineActive;
  logic [13:0] sylData;

  // Round robin only matters when both ask; reset favours A by marking B as last.
  assign grantB  = b_req && (!a_req || !lastGrantB);
  assign sylData = sylCur ? wordQ[27:14] : wordQ[13:0];

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (a_req || b_req) nextState = SETUP;
      SETUP:   if (timer == SETUP_LAST) nextState = SYNC;
      SYNC:    if (timer == SAMPLE_LAST) nextState = SAMPLE;
      SAMPLE:  nextState = RECOVER;
      RECOVER: if (timer == RECOVER_LAST) nextState = (txn.word && !sylCur) ? SETUP : DONE;
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    lineActive = (state == SETUP) || (state == SYNC) || (state == SAMPLE);
    ax_n    = 8'hFF;
    ay_n    = 8'hFF;
    ax0_n   = 8'hFF;
    ay0_n   = 8'hFF;
    syl0_n  = 1'b1;
    syl1_n  = 1'b1;
    rdm_v   = 1'b0;
    rdm_vn  = 1'b1;
    sync_v  = 1'b0;
    inhbs_v = 1'b1;
    a_ack   = 1'b0;
    b_ack   = 1'b0;
    rsp_err = 1'b0;
    if (lineActive) begin
      ax_n    = ~(8'h01 << txn.addr[2:0]);
      ay_n    = ~(8'h01 << txn.addr[5:3]);
      ax0_n   = ~(8'h01 << txn.addr[8:6]);
      ay0_n   = ~(8'h01 << txn.addr[11:9]);
      syl0_n  = sylCur;
      syl1_n  = !sylCur;
      rdm_v   = 1'b1;
      rdm_vn  = 1'b0;
      inhbs_v = 1'b0;
    end
    if (state == SYNC && timer < SYNC_WIDTH) sync_v = 1'b1;
    if (state == DONE) begin
      a_ack   = !txn.portB;
      b_ack   = txn.portB;
      rsp_err = errAcc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      timer <= 6'd0;
    end else begin
      state <= nextState;
      if (nextState != state) timer <= 6'd0;
      else if (state != IDLE && state != DONE) timer <= timer + 6'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      txn        <= '0;
      sylCur     <= 1'b0;
      lastGrantB <= 1'b1;
      edxSeen    <= 1'b0;
      edySeen    <= 1'b0;
      errAcc     <= 1'b0;
      wordQ      <= '0;
      a_data     <= '0;
      b_data     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (a_req || b_req) begin
            txn.portB <= grantB;
            txn.word  <= grantB && b_word;
            txn.addr  <= grantB ? b_addr : a_addr;
            sylCur    <= grantB ? (!b_word && b_syl) : a_syl;
          end
        end
        SETUP: begin
          edxSeen <= 1'b0;
          edySeen <= 1'b0;
        end
        SYNC: begin
          if (ed_x) edxSeen <= 1'b1;
          if (ed_y) edySeen <= 1'b1;
        end
        SAMPLE: begin
          if (sylCur) wordQ[27:14] <= sa;
          else        wordQ[13:0]  <= sa;
          // Include this cycle's detect inputs, since the seen flags only update next edge.
          if (!((edxSeen || ed_x) && (edySeen || ed_y))) errAcc <= 1'b1;
        end
        RECOVER: begin
          if (nextState == SETUP) sylCur <= 1'b1;
          if (nextState == DONE) begin
            if (!txn.portB)    a_data <= sylData;
            else if (txn.word) b_data <= wordQ;
            else               b_data <= {14'd0, sylData};
          end
        end
        DONE: begin
          lastGrantB <= txn.portB;
          errAcc     <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_core_read_sequencer.sv
// Directed bench: stimulus pushes expected acks into a scoreboard; a monitor pops and compares on each ack.
module tb_core_read_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        a_req = 1'b0;
  logic [11:0] a_addr = '0;
  logic        a_syl = 1'b0;
  logic        a_ack;
  logic [13:0] a_data;
  logic        b_req = 1'b0;
  logic [11:0] b_addr = '0;
  logic        b_word = 1'b0;
  logic        b_syl = 1'b0;
  logic        b_ack;
  logic [27:0] b_data;
  logic        rsp_err;
  logic [7:0]  ax_n, ay_n, ax0_n, ay0_n;
  logic        syl0_n, syl1_n, rdm_v, rdm_vn, sync_v, inhbs_v;
  logic [13:0] sa = '0;
  logic        ed_x = 1'b0;
  logic        ed_y = 1'b0;

  logic [13:0] sa0 = '0;
  logic [13:0] sa1 = '0;
  bit          killY2 = 1'b0;

  int cyc = 0;
  int nChecks = 0;
  int nFail = 0;

  typedef struct {
    bit          portB;
    logic [27:0] data;
    bit          err;
    int          cyc;
  } exp_t;
  exp_t sbq[$];

  core_read_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_addr(a_addr), .a_syl(a_syl), .a_ack(a_ack), .a_data(a_data),
    .b_req(b_req), .b_addr(b_addr), .b_word(b_word), .b_syl(b_syl), .b_ack(b_ack), .b_data(b_data),
    .rsp_err(rsp_err),
    .ax_n(ax_n), .ay_n(ay_n), .ax0_n(ax0_n), .ay0_n(ay0_n),
    .syl0_n(syl0_n), .syl1_n(syl1_n), .rdm_v(rdm_v), .rdm_vn(rdm_vn),
    .sync_v(sync_v), .inhbs_v(inhbs_v),
    .sa(sa), .ed_x(ed_x), .ed_y(ed_y)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic pushExp(input bit portB, input logic [27:0] data, input bit err, input int ackCyc);
    exp_t e;
    e.portB = portB;
    e.data  = data;
    e.err   = err;
    e.cyc   = ackCyc;
    sbq.push_back(e);
  endtask

  task automatic waitAcks(input int n, input int maxCyc, output int syncCnt,
                          output int syl0Cnt, output int syl1Cnt);
    int got = 0;
    syncCnt = 0;
    syl0Cnt = 0;
    syl1Cnt = 0;
    for (int i = 0; i < maxCyc; i++) begin
      @(negedge clk);
      if (sync_v) syncCnt++;
      if (!syl0_n) syl0Cnt++;
      if (!syl1_n) syl1Cnt++;
      if (a_ack || b_ack) got++;
      if (got == n) break;
    end
    chk("acks_within_budget", got, n);
  endtask

  // Core module model: detect lines follow sync, sense amps present the selected syllable.
  initial forever begin
    @(negedge clk);
    ed_x = sync_v;
    ed_y = sync_v && !(killY2 && !syl1_n);
    sa   = !syl0_n ? sa0 : (!syl1_n ? sa1 : 14'h0);
  end

  // Monitor: every ack must match the head of the scoreboard.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (a_ack || b_ack) begin
      if (sbq.size() == 0) begin
        chk("unexpected_ack", {30'd0, a_ack, b_ack}, 32'd0);
      end else begin
        e = sbq.pop_front();
        chk("ack_port_b", {31'd0, b_ack}, {31'd0, e.portB});
        chk("ack_port_a", {31'd0, a_ack}, {31'd0, !e.portB});
        chk("ack_data", b_ack ? {4'd0, b_data} : {18'd0, a_data}, {4'd0, e.data});
        chk("ack_err", {31'd0, rsp_err}, {31'd0, e.err});
        chk("ack_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s, c0, c1, c;
    int rdmCnt, aAckCnt;

    repeat (3) @(negedge clk);
    chk("rst_addr", {ax_n, ay_n, ax0_n, ay0_n}, 32'hFFFF_FFFF);
    chk("rst_syl", {30'd0, syl0_n, syl1_n}, 32'd3);
    chk("rst_ctl", {28'd0, rdm_v, rdm_vn, sync_v, inhbs_v}, 32'b0101);
    chk("rst_ack", {29'd0, a_ack, b_ack, rsp_err}, 32'd0);
    chk("rst_data", {4'd0, b_data} | {18'd0, a_data}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // A syllable 0 read, address 1234 octal
    a_addr = 12'o1234; a_syl = 1'b0; sa0 = 14'h2A5A;
    pushExp(1'b0, 28'h0002A5A, 1'b0, cyc + 17);
    a_req = 1'b1;
    @(negedge clk);
    chk("a_setup_addr", {ax_n, ay_n, ax0_n, ay0_n}, 32'hEFF7_FBFD);
    chk("a_setup_syl", {30'd0, syl0_n, syl1_n}, 32'b01);
    chk("a_setup_ctl", {28'd0, rdm_v, rdm_vn, sync_v, inhbs_v}, 32'b1000);
    waitAcks(1, 40, s, c0, c1);
    a_req = 1'b0;
    chk("a_sync_cycles", s, 2);
    chk("a_syl0_cycles", c0, 12);
    chk("a_syl1_cycles", c1, 0);
    @(negedge clk);
    chk("a_data_hold", {18'd0, a_data}, 32'h2A5A);
    chk("idle_lines", {ax_n, ay_n, ax0_n, ay0_n}, 32'hFFFF_FFFF);

    // B full word read, address 7777 octal
    b_addr = 12'o7777; b_word = 1'b1; b_syl = 1'b0; sa0 = 14'h0001; sa1 = 14'h3FFF;
    pushExp(1'b1, 28'hFFFC001, 1'b0, cyc + 33);
    b_req = 1'b1;
    @(negedge clk);
    chk("b_setup_addr", {ax_n, ay_n, ax0_n, ay0_n}, 32'h7F7F_7F7F);
    waitAcks(1, 60, s, c0, c1);
    b_req = 1'b0;
    chk("b_sync_cycles", s, 4);
    chk("b_syl0_cycles", c0, 12);
    chk("b_syl1_cycles", c1, 13);
    @(negedge clk);

    // Simultaneous requests: A first, B right after A's DONE
    a_addr = 12'o0005; a_syl = 1'b1; b_addr = 12'o0100; b_word = 1'b0; b_syl = 1'b0;
    sa0 = 14'h1111; sa1 = 14'h2222;
    pushExp(1'b0, 28'h0002222, 1'b0, cyc + 17);
    pushExp(1'b1, 28'h0001111, 1'b0, cyc + 35);
    a_req = 1'b1; b_req = 1'b1;
    waitAcks(1, 40, s, c0, c1);
    a_req = 1'b0;
    waitAcks(1, 40, s, c0, c1);
    b_req = 1'b0;
    @(negedge clk);

    // Both held: grants alternate A, B, A, B
    a_syl = 1'b0; sa0 = 14'h0F0F;
    c = cyc;
    pushExp(1'b0, 28'h0000F0F, 1'b0, c + 17);
    pushExp(1'b1, 28'h0000F0F, 1'b0, c + 35);
    pushExp(1'b0, 28'h0000F0F, 1'b0, c + 53);
    pushExp(1'b1, 28'h0000F0F, 1'b0, c + 71);
    a_req = 1'b1; b_req = 1'b1;
    waitAcks(4, 100, s, c0, c1);
    a_req = 1'b0; b_req = 1'b0;
    @(negedge clk);

    // Missing Y drive detect on pass 2 of a word read
    b_addr = 12'o0012; b_word = 1'b1; sa0 = 14'h0ABC; sa1 = 14'h1DEF; killY2 = 1'b1;
    pushExp(1'b1, {14'h1DEF, 14'h0ABC}, 1'b1, cyc + 33);
    b_req = 1'b1;
    waitAcks(1, 60, s, c0, c1);
    b_req = 1'b0; killY2 = 1'b0;
    @(negedge clk);
    a_addr = 12'o4321; a_syl = 1'b1; sa1 = 14'h1234;
    pushExp(1'b0, 28'h0001234, 1'b0, cyc + 17);
    a_req = 1'b1;
    waitAcks(1, 40, s, c0, c1);
    a_req = 1'b0;
    @(negedge clk);

    // Reset during SYNC discards the read; held req restarts it from scratch
    a_addr = 12'o0707; a_syl = 1'b0; sa0 = 14'h0555;
    a_req = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (sync_v) break;
    end
    chk("reached_sync", {31'd0, sync_v}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_sync_addr", {ax_n, ay_n, ax0_n, ay0_n}, 32'hFFFF_FFFF);
    chk("rst_sync_ctl", {28'd0, rdm_v, rdm_vn, sync_v, inhbs_v}, 32'b0101);
    repeat (2) @(negedge clk);
    pushExp(1'b0, 28'h0000555, 1'b0, cyc + 17);
    rst_n = 1'b1;
    waitAcks(1, 40, s, c0, c1);
    a_req = 1'b0;
    @(negedge clk);

    // A request withdrawn while B is in service is never served
    b_addr = 12'o3333; b_word = 1'b0; b_syl = 1'b1; sa1 = 14'h3C3C;
    pushExp(1'b1, 28'h0003C3C, 1'b0, cyc + 17);
    b_req = 1'b1;
    repeat (3) @(negedge clk);
    a_req = 1'b1;
    repeat (4) @(negedge clk);
    a_req = 1'b0;
    waitAcks(1, 40, s, c0, c1);
    b_req = 1'b0;
    rdmCnt = 0;
    aAckCnt = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (rdm_v) rdmCnt++;
      if (a_ack) aAckCnt++;
    end
    chk("withdrawn_no_cycle", rdmCnt, 0);
    chk("withdrawn_no_ack", aAckCnt, 0);

    chk("scoreboard_empty", sbq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule

// File: doc/core_read_sequencer.md
Name: core_read_sequencer

Overview:
- Sequences read cycles of one LVDC core memory module for two requesters.
  - Port A: 14-bit syllable reads, used by instruction fetch.
  - Port B: syllable or full 28-bit word reads, used by operand access.
- Arbitrates between the ports, drives the module's active-low one-hot X/Y address lines, syllable selects and read/sync/inhibit controls, and captures sense-amp outputs.
- Checks that both X and Y drive-detect lines pulsed during each cycle and flags an error if not.

Parameters:
SETUP_CYC, 2, cycles address/syllable/read lines are held before sync rises (1..15)
SYNC_CYC, 2, width of sync_v pulse in cycles (1..15)
SAMPLE_CYC, 10, cycles from first sync_v-high cycle to sense-amp capture (> SYNC_CYC, <= 63)
RECOVER_CYC, 3, cycles with all lines released between core cycles (1..15)

Ports:
clk  in  1  system clock
rst_n  in  1  reset; asynchronous, active-low
a_req  in  1  port A request, held until a_ack
a_addr  in  12  port A word address
a_syl  in  1  port A syllable: 0 = bits 14:1, 1 = bits 28:15
a_ack  out  1  one-cycle completion pulse, port A
a_data  out  14  port A syllable, valid while a_ack
b_req  in  1  port B request, held until b_ack
b_addr  in  12  port B word address
b_word  in  1  1 = full word (two core cycles), 0 = single syllable
b_syl  in  1  syllable when b_word=0
b_ack  out  1  one-cycle completion pulse, port B
b_data  out  28  port B data; syllable reads return value in [13:0], zeros in [27:14]
rsp_err  out  1  valid with either ack: drive-detect failure in any core cycle of the transaction
ax_n  out  8  one-hot active-low decode of addr[2:0]
ay_n  out  8  one-hot active-low decode of addr[5:3]
ax0_n  out  8  one-hot active-low decode of addr[8:6]
ay0_n  out  8  one-hot active-low decode of addr[11:9]
syl0_n  out  1  low selects syllable 0
syl1_n  out  1  low selects syllable 1
rdm_v  out  1  read-mode, active-high
rdm_vn  out  1  complement of rdm_v
sync_v  out  1  memory sync pulse
inhbs_v  out  1  sense strobe inhibit; high when idle
sa  in  14  sense-amp outputs
ed_x  in  1  X drive detect
ed_y  in  1  Y drive detect

Behaviour:
- States: IDLE, SETUP, SYNC, SAMPLE, RECOVER, DONE. A single 6-bit timer serves all timed states.
- Reset (async, any state):
  - All address outputs 8'hFF; syl0_n = syl1_n = 1.
  - rdm_v = 0, rdm_vn = 1, sync_v = 0, inhbs_v = 1.
  - Acks 0, data 0, rsp_err 0, last-grant = B.
  - An in-flight transaction is discarded with no ack. The requester re-presents it by holding req.
- IDLE: requests are sampled here only.
  - One port requesting: grant it.
  - Both requesting: grant the port not granted last (round robin).
  - Latch the granted port, address, mode and syllable, then go to SETUP.
  - Port inputs are ignored outside IDLE.
- SETUP (SETUP_CYC cycles):
  - Decoded address lines asserted (exactly one low per group).
  - The selected syl*_n is low.
  - rdm_v = 1, inhbs_v = 0.
  - Clear edx_seen/edy_seen at entry.
- SYNC (SAMPLE_CYC cycles): sync_v high for the first SYNC_CYC cycles. Address, syllable and rdm lines are held throughout.
- Drive-detect tracking: edx_seen/edy_seen set on any cycle of SYNC or SAMPLE where ed_x/ed_y = 1.
- SAMPLE (1 cycle): capture sa into word register bits [13:0] (syl 0) or [27:14] (syl 1). Accumulate err |= !(edx_seen & edy_seen).
- RECOVER (RECOVER_CYC cycles): all lines at their reset/idle values.
  - Then, if word mode and first pass: repeat SETUP with syllable 1 (first pass used syllable 0).
  - Otherwise go to DONE.
- DONE (1 cycle):
  - Granted port's ack = 1 with data.
  - rsp_err = accumulated err.
  - Update last-grant; clear err; go to IDLE.
- Latency with defaults: req sampled at edge t gives ack high in cycle t+17 (syllable) or t+33 (word).
- Back-to-back: a req still high in IDLE after its ack is a new request.
- Data outputs hold their last value after ack. a_data / b_data change only in DONE.

Test Plan:
- Reset, then A: addr 12'o1234, syl 0, sa = 14'h2A5A, ed_x/ed_y pulsed during SYNC -> ax_n = 8'hEF, ay_n = 8'hF7, ax0_n = 8'hFB, ay0_n = 8'hFD, syl0_n = 0; sync_v high 2 cycles; a_ack at t+17; a_data = 14'h2A5A; rsp_err = 0.
- B word, addr 12'o7777: sa = 14'h0001 on pass 1 and 14'h3FFF on pass 2 -> b_ack at t+33, b_data = 28'hFFFC001, syl0_n low pass 1, syl1_n low pass 2.
- A and B request in the same IDLE cycle after reset -> A granted first, B immediately after A's DONE. Repeat with both held -> grants alternate A, B, A, B.
- ed_y never asserted during pass 2 of a B word read -> b_ack with rsp_err = 1. Next clean transaction -> rsp_err = 0.
- rst_n low during SYNC of an A read -> all address lines 8'hFF, sync_v = 0, inhbs_v = 1 immediately; no a_ack. Release with a_req held -> full fresh cycle, ack at 17 cycles after first IDLE sample.
- a_req withdrawn while B is in service -> after B's DONE the FSM stays IDLE and issues no A cycle.
